// File: rtl/global_bkt_clear.sv
// Global rollback after a backtrack decision: zeroes lvl_states entries above
// the backtrack level, unassigns var_states entries decided above it, then
// pulses done_bkt for the bin manager.
module global_bkt_clear #(
  parameter int WIDTH_LVL              = 16,
  parameter int WIDTH_BIN_ID           = 10,
  parameter int WIDTH_LVL_STATES       = 11,
  parameter int ADDR_WIDTH_LVLS_STATES = 9,
  parameter int WIDTH_VAR_STATES       = 19,
  parameter int ADDR_WIDTH_VAR_STATES  = 9
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_bkt,
  input  logic [WIDTH_LVL-1:0]              bkt_lvl_i,
  input  logic [WIDTH_BIN_ID-1:0]           bkt_bin_i,
  input  logic [WIDTH_LVL-1:0]              cur_lvl_i,
  input  logic [ADDR_WIDTH_VAR_STATES:0]    num_vars_i,
  output logic                              apply_bkt_o,
  output logic                              done_bkt,
  output logic [WIDTH_LVL-1:0]              cur_lvl_o,
  output logic [WIDTH_BIN_ID-1:0]           bkt_bin_o,
  output logic [ADDR_WIDTH_VAR_STATES:0]    cleared_cnt_o,
  output logic                              ram_we_l_state_o,
  output logic [WIDTH_LVL_STATES-1:0]       ram_data_l_state_o,
  output logic [ADDR_WIDTH_LVLS_STATES-1:0] ram_addr_l_state_o,
  output logic                              ram_we_v_state_o,
  input  logic [WIDTH_VAR_STATES-1:0]       ram_data_v_state_i,
  output logic [WIDTH_VAR_STATES-1:0]       ram_data_v_state_o,
  output logic [ADDR_WIDTH_VAR_STATES-1:0]  ram_addr_v_state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR_LVL, S_RD_VAR, S_CHK_VAR, S_DONE
  } state_t;

  state_t                            r_state, w_next;
  logic [WIDTH_LVL-1:0]              r_bkt_lvl;
  logic [WIDTH_BIN_ID-1:0]           r_bkt_bin;
  logic [ADDR_WIDTH_VAR_STATES:0]    r_num_vars;
  logic [WIDTH_LVL-1:0]              r_lvl_cnt;
  logic [ADDR_WIDTH_VAR_STATES:0]    r_var_cnt;
  logic [ADDR_WIDTH_VAR_STATES:0]    r_cleared;

  logic [1:0]                        w_var_val;
  logic [WIDTH_LVL-1:0]              w_var_lvl;
  logic                              w_unused_implied;
  logic [WIDTH_LVL-1:0]              w_bkt_lvl_p1;
  logic                              w_last_lvl;
  logic                              w_last_var;
  logic                              w_we_l, w_we_v, w_apply, w_done;
  logic [ADDR_WIDTH_LVLS_STATES-1:0] w_addr_l;
  logic [ADDR_WIDTH_VAR_STATES-1:0]  w_addr_v;

  // var_states word = {value[1:0], implied, lvl}; the implied flag plays no
  // part in rollback.
  assign w_var_val        = ram_data_v_state_i[WIDTH_VAR_STATES-1 -: 2];
  assign w_var_lvl        = ram_data_v_state_i[WIDTH_LVL-1:0];
  assign w_unused_implied = ram_data_v_state_i[WIDTH_LVL];

  assign w_bkt_lvl_p1 = r_bkt_lvl + {{(WIDTH_LVL-1){1'b0}}, 1'b1};
  assign w_last_lvl   = (r_lvl_cnt == w_bkt_lvl_p1);
  assign w_last_var   = (r_var_cnt == r_num_vars - {{ADDR_WIDTH_VAR_STATES{1'b0}}, 1'b1});

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and BRAM control decode. The var write enable in CHK_VAR is
  // decoded from the BRAM read data, which is itself a registered BRAM output.
  always_comb begin
    w_next   = r_state;
    w_we_l   = 1'b0;
    w_we_v   = 1'b0;
    w_addr_l = '0;
    w_addr_v = '0;
    w_apply  = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_bkt) begin
          if (cur_lvl_i > bkt_lvl_i)   w_next = S_CLR_LVL;
          else if (num_vars_i != '0)   w_next = S_RD_VAR;
          else                         w_next = S_DONE;
        end
      end
      S_CLR_LVL: begin
        w_apply  = 1'b1;
        w_we_l   = 1'b1;
        w_addr_l = r_lvl_cnt[ADDR_WIDTH_LVLS_STATES-1:0];
        if (w_last_lvl) w_next = (r_num_vars != '0) ? S_RD_VAR : S_DONE;
      end
      S_RD_VAR: begin
        w_apply  = 1'b1;
        w_addr_v = r_var_cnt[ADDR_WIDTH_VAR_STATES-1:0];
        w_next   = S_CHK_VAR;
      end
      S_CHK_VAR: begin
        w_apply  = 1'b1;
        w_addr_v = r_var_cnt[ADDR_WIDTH_VAR_STATES-1:0];
        w_we_v   = (w_var_val != 2'd0) && (w_var_lvl > r_bkt_lvl);
        w_next   = w_last_var ? S_DONE : S_RD_VAR;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latches the run parameters at start and steps the level/var counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bkt_lvl  <= '0;
      r_bkt_bin  <= '0;
      r_num_vars <= '0;
      r_lvl_cnt  <= '0;
      r_var_cnt  <= '0;
      r_cleared  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_bkt) begin
            r_bkt_lvl  <= bkt_lvl_i;
            r_bkt_bin  <= bkt_bin_i;
            r_num_vars <= num_vars_i;
            r_lvl_cnt  <= cur_lvl_i;
            r_var_cnt  <= '0;
            r_cleared  <= '0;
          end
        end
        S_CLR_LVL: begin
          if (!w_last_lvl) r_lvl_cnt <= r_lvl_cnt - {{(WIDTH_LVL-1){1'b0}}, 1'b1};
        end
        S_CHK_VAR: begin
          if (w_we_v)      r_cleared <= r_cleared + {{ADDR_WIDTH_VAR_STATES{1'b0}}, 1'b1};
          if (!w_last_var) r_var_cnt <= r_var_cnt + {{ADDR_WIDTH_VAR_STATES{1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

  assign apply_bkt_o        = w_apply;
  assign done_bkt           = w_done;
  assign cur_lvl_o          = r_bkt_lvl;
  assign bkt_bin_o          = r_bkt_bin;
  assign cleared_cnt_o      = r_cleared;
  assign ram_we_l_state_o   = w_we_l;
  assign ram_addr_l_state_o = w_addr_l;
  assign ram_data_l_state_o = '0;
  assign ram_we_v_state_o   = w_we_v;
  assign ram_addr_v_state_o = w_addr_v;
  assign ram_data_v_state_o = '0;

endmodule
